add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 118 +++++++++++
 tb/tb_add_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Two-requester arbiter sharing one registered adder; one transaction in flight at a time.
// Define ADD_ARB_ROUND_ROBIN_EN for round-robin tie-break, otherwise requester 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; ready asserted for the granted requester
// ISSUE | operands on add_a/add_b, adder registering them
// WAIT  | adder result valid, captured on the exit edge
// RESP  | rsp_valid high, held until rsp_ready
module add_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W:0]   add_sum,
    input  logic         add_odd,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W:0]   rsp_sum,
    output logic         rsp_odd,
    input  logic         rsp_ready,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t       state_q;
    logic [W-1:0] op_a_q, op_b_q;
    logic [W-1:0] op_a_d, op_b_d;
    logic         rsp_id_q;
    logic [W:0]   rsp_sum_q;
    logic         rsp_odd_q;
    logic [7:0]   cnt0_q, cnt1_q;
    logic         tie_pick1;
    logic         idle;
    logic         accept;
    logic         sel1;

`ifdef ADD_ARB_ROUND_ROBIN_EN
    logic last_q;
    // on a tie, grant whoever did not win last time
    assign tie_pick1 = ~last_q;
`else
    assign tie_pick1 = 1'b0;
`endif

    assign idle       = (state_q == IDLE);
    assign req0_ready = idle & req0_valid & (~req1_valid | ~tie_pick1);
    assign req1_ready = idle & req1_valid & (~req0_valid | tie_pick1);
    assign accept     = req0_ready | req1_ready;
    assign sel1       = req1_ready;
    assign op_a_d     = sel1 ? req1_a : req0_a;
    assign op_b_d     = sel1 ? req1_b : req0_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rsp_id_q  <= 1'b0;
            rsp_sum_q <= '0;
            rsp_odd_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
`ifdef ADD_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q   <= op_a_d;
                        op_b_q   <= op_b_d;
                        rsp_id_q <= sel1;
`ifdef ADD_ARB_ROUND_ROBIN_EN
                        last_q   <= sel1;
`endif
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    rsp_sum_q <= add_sum;
                    rsp_odd_q <= add_odd;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (rsp_id_q) cnt1_q <= cnt1_q + 8'd1;
                        else          cnt0_q <= cnt0_q + 8'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_odd   = rsp_odd_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_add_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] add_a, add_b;
    logic [W:0]   add_sum = '0;
    logic         add_odd = 1'b0;
    logic         rsp_valid, rsp_id, rsp_odd;
    logic [W:0]   rsp_sum;
    logic         rsp_ready = 1'b0;
    logic [7:0]   cnt0, cnt1;

    add_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_odd(add_odd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_odd(rsp_odd),
        .rsp_ready(rsp_ready), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // external registered adder
    always_ff @(posedge clk) begin
        add_sum <= {1'b0, add_a} + {1'b0, add_b};
        add_odd <= add_a[0] ^ add_b[0];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // reference model: one transaction in flight, tracked by edges since acceptance
    bit model_ok = 0;
    bit m_busy = 0;
    int m_age = 0;
    int m_id = 0;
    int m_a = 0, m_b = 0;
    int m_cnt[2] = '{0, 0};
    int m_last = 1;
    int m_pick;

    function automatic int pick(input bit v0, input bit v1, input int last);
        if (v0 && v1) begin
`ifdef ADD_ARB_ROUND_ROBIN_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1;
            m_busy = 0; m_age = 0; m_id = 0; m_a = 0; m_b = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
        end else if (!m_busy) begin
            m_pick = pick(req0_valid, req1_valid, m_last);
            if (m_pick >= 0) begin
                m_busy = 1; m_age = 0; m_id = m_pick; m_last = m_pick;
                m_a = (m_pick == 1) ? int'(req1_a) : int'(req0_a);
                m_b = (m_pick == 1) ? int'(req1_b) : int'(req0_b);
            end
        end else if (m_age >= 2 && rsp_ready) begin
            m_cnt[m_id] = (m_cnt[m_id] + 1) % 256;
            m_busy = 0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (model_ok && !reset) begin
            int p;
            bit ev;
            p = m_busy ? -1 : pick(req0_valid, req1_valid, m_last);
            ev = m_busy && (m_age >= 2);
            chk("req0_ready", req0_ready, (p == 0));
            chk("req1_ready", req1_ready, (p == 1));
            chk("add_a", add_a, m_a);
            chk("add_b", add_b, m_b);
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_id", rsp_id, m_id);
            chk("cnt0", cnt0, m_cnt[0]);
            chk("cnt1", cnt1, m_cnt[1]);
            if (ev) begin
                chk("rsp_sum", rsp_sum, m_a + m_b);
                chk("rsp_odd", rsp_odd, (m_a + m_b) % 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ids[4];
        int done;
        int cyc;

        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);

        // single req0 transaction
        tick();
        req0_valid = 1; req0_a = 5; req0_b = 6; rsp_ready = 1;
        @(negedge clk);
        chk("t1_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        wait_rsp(n);
        chk("t1_latency", n, 3);
        chk("t1_sum", rsp_sum, 11);
        chk("t1_odd", rsp_odd, 1);
        chk("t1_id", rsp_id, 0);
        @(negedge clk);
        chk("t1_cnt0", cnt0, 1);
        chk("t1_valid_low", rsp_valid, 0);

        // req1 overflow sum with backpressure
        tick();
        rsp_ready = 0; req1_valid = 1; req1_a = 255; req1_b = 1;
        @(negedge clk);
        chk("t2_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        wait_rsp(n);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("t2_hold_valid", rsp_valid, 1);
            chk("t2_hold_sum", rsp_sum, 256);
            chk("t2_hold_odd", rsp_odd, 0);
            chk("t2_hold_id", rsp_id, 1);
            chk("t2_hold_cnt1", cnt1, 0);
        end
        tick();
        rsp_ready = 1;
        @(negedge clk);
        chk("t2_pre_cnt1", cnt1, 0);
        tick();
        @(negedge clk);
        chk("t2_cnt1", cnt1, 1);

        // both requesters continuously valid
        tick();
        req0_valid = 1; req0_a = 10; req0_b = 3;
        req1_valid = 1; req1_a = 20; req1_b = 7;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(n);
            ids[i] = int'(rsp_id);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
`ifdef ADD_ARB_ROUND_ROBIN_EN
        chk("t3_id0", ids[0], 0); chk("t3_id1", ids[1], 1);
        chk("t3_id2", ids[2], 0); chk("t3_id3", ids[3], 1);
`else
        chk("t3_id0", ids[0], 0); chk("t3_id1", ids[1], 0);
        chk("t3_id2", ids[2], 0); chk("t3_id3", ids[3], 0);
`endif

        // reset during WAIT aborts the transaction
        tick();
        req0_valid = 1; req0_a = 2; req0_b = 2; rsp_ready = 1;
        tick();
        req0_valid = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_no_rsp", rsp_valid, 0);
        end
        chk("t4_cnt0", cnt0, 0);
        tick();
        req0_valid = 1; req0_a = 3; req0_b = 4;
        tick();
        req0_valid = 0;
        wait_rsp(n);
        chk("t4_sum", rsp_sum, 7);
        chk("t4_odd", rsp_odd, 1);
        @(negedge clk);
        chk("t4_cnt0_after", cnt0, 1);

        // 256 req0 completions, req1 valid only while busy
        tick();
        reset = 1;
        tick();
        reset = 0;
        rsp_ready = 1;
        done = 0;
        cyc = 0;
        while (done < 256 && cyc < 3000) begin
            tick();
            req0_valid = 1;
            req0_a = W'($urandom_range(0, 255));
            req0_b = W'($urandom_range(0, 255));
            req1_valid = m_busy;
            @(negedge clk);
            if (req1_valid) chk("t5_req1_ready_busy", req1_ready, 0);
            if (rsp_valid) begin
                done++;
                if (done == 256) chk("t5_cnt0_255", cnt0, 255);
            end
            cyc++;
        end
        chk("t5_done", done, 256);
        tick();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("t5_cnt0_wrap", cnt0, 0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            reset = ($urandom_range(0, 99) == 0);
            req0_valid = $urandom_range(0, 1) != 0;
            req1_valid = $urandom_range(0, 1) != 0;
            req0_a = W'($urandom_range(0, 255));
            req0_b = W'($urandom_range(0, 255));
            req1_a = W'($urandom_range(0, 255));
            req1_b = W'($urandom_range(0, 255));
            rsp_ready = $urandom_range(0, 2) != 0;
        end
        tick();
        reset = 0; req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
